regfile_sb: RTL

- Parametrised successor to the single-cycle CPU register file, for the pipelined/multicycle core.
- Provides NREAD combinational read ports and NWRITE synchronous write ports.
- Adds a per-register pending-write scoreboard: issue increments, writeback decrements. Decode uses it to detect RAW hazards and stall.
- Sits between decode (read/issue) and writeback (write/clear).

---
 rtl/regfile_sb.sv | 115 +++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes and retiring clears to the read ports.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREAD*ADDR_W-1:0]  ra,
    output logic [NREAD*DATA_W-1:0]  rd,
    output logic [NREAD-1:0]         rbusy,
    input  logic [NWRITE-1:0]        we,
    input  logic [NWRITE*ADDR_W-1:0] wa,
    input  logic [NWRITE*DATA_W-1:0] wd,
    input  logic [NWRITE-1:0]        wclr,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_ready,
    output logic                     sb_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs    [NREG];
    logic [CNT_W-1:0]  cnt     [NREG];
    logic [CNT_W-1:0]  cnt_nxt [NREG];
    int                nclr    [NREG];
    logic [ADDR_W-1:0] ras     [NREAD];
    logic [ADDR_W-1:0] was     [NWRITE];
    logic [DATA_W-1:0] wds     [NWRITE];
    logic [CNT_W-1:0]  icnt;
    logic              issue_ok;
    logic              under;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a != '0 && int'(a) < NREG;
    endfunction

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        assign ras[g] = ra[g*ADDR_W +: ADDR_W];
    end

    for (genvar g = 0; g < NWRITE; g++) begin : g_wr
        assign was[g] = wa[g*ADDR_W +: ADDR_W];
        assign wds[g] = wd[g*DATA_W +: DATA_W];
    end

    always_comb begin
        rd = '0;
        rbusy = '0;
        for (int i = 0; i < NREAD; i++)
            for (int r = 1; r < NREG; r++)
                if (ras[i] == ADDR_W'(r)) begin
                    rd[i*DATA_W +: DATA_W] = regs[r];
`ifdef REGFILE_BYPASS_EN
                    rbusy[i] = int'(cnt[r]) > nclr[r];
`else
                    rbusy[i] = cnt[r] != '0;
`endif
                end
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NREAD; i++)
            for (int k = 0; k < NWRITE; k++)
                if (!reset && we[k] && in_range(was[k]) && was[k] == ras[i])
                    rd[i*DATA_W +: DATA_W] = wds[k];
`endif
    end

    // A full counter blocks issue even if a clear retires in the same cycle.
    always_comb begin
        icnt = '0;
        for (int r = 1; r < NREG; r++)
            if (issue_addr == ADDR_W'(r))
                icnt = cnt[r];
        issue_ready = !(issue_addr != '0 && icnt == CNT_MAX);
        issue_ok = issue_valid && issue_ready && in_range(issue_addr);
        under = 1'b0;
        nclr[0] = 0;
        cnt_nxt[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            nclr[r] = 0;
            for (int k = 0; k < NWRITE; k++)
                if (we[k] && wclr[k] && was[k] == ADDR_W'(r))
                    nclr[r] = nclr[r] + 1;
            if (nclr[r] > int'(cnt[r]) + ((issue_ok && issue_addr == ADDR_W'(r)) ? 1 : 0)) begin
                under = 1'b1;
                cnt_nxt[r] = '0;
            end else begin
                cnt_nxt[r] = CNT_W'(int'(cnt[r]) + ((issue_ok && issue_addr == ADDR_W'(r)) ? 1 : 0) - nclr[r]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_nxt[r];
            // Later ports overwrite earlier ones, so the highest index wins.
            for (int r = 1; r < NREG; r++)
                for (int k = 0; k < NWRITE; k++)
                    if (we[k] && was[k] == ADDR_W'(r))
                        regs[r] <= wds[k];
            sb_err <= sb_err | under;
        end
    end
endmodule
